// File: rtl/fb_pkg.sv
// fb_pkg: shared types and constants for the frame-buffer write scheduler.
//   fb_addr_t      - 18-bit frame-RAM word address
//   FB_WIDTH/...   - default frame-buffer geometry
//   sched_state_t  - scheduler FSM states
package fb_pkg;

  typedef logic [17:0] fb_addr_t;

  localparam int unsigned FB_WIDTH  = 800;
  localparam int unsigned FB_HEIGHT = 320;
  localparam int unsigned FB_WORDS  = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/fb_clear_gen.sv
// fb_clear_gen: address/data generator for the frame-buffer clear engine.
// Optional feature macro: FB_TESTPAT_EN (clear data becomes col[4] ^ row[4]).
// Ports:
//   i_dotclk   - clock
//   i_reset    - synchronous active-high reset
//   i_start    - restart the sweep at word 0
//   i_advance  - the current word was granted; step to the next one
//   o_addr     - current clear address
//   o_data     - clear data for the current word
//   o_last     - current word is the final word of the frame
module fb_clear_gen
  import fb_pkg::*;
#(
  parameter int unsigned Width = fb_pkg::FB_WIDTH,
  parameter int unsigned Words = fb_pkg::FB_WORDS
) (
  input  logic     i_dotclk,
  input  logic     i_reset,
  input  logic     i_start,
  input  logic     i_advance,
  output fb_addr_t o_addr,
  output logic     o_data,
  output logic     o_last
);

  localparam fb_addr_t LastAddr = fb_addr_t'(Words - 1);

  if (Width == 0 || Width > 1024) begin : g_bad_width
    $error("fb_clear_gen: Width must be in 1..1024");
  end

  fb_addr_t r_ptr;

  // Start wins over advance so a restart on a granted cycle lands on 0.
  always_ff @(posedge i_dotclk) begin
    if (i_reset || i_start) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= r_ptr + 18'd1;
    end
  end

  assign o_addr = r_ptr;
  assign o_last = (r_ptr == LastAddr);

`ifdef FB_TESTPAT_EN
  localparam logic [9:0] LastCol = 10'(Width - 1);

  logic [9:0] r_col;
  logic [8:0] r_row;

  always_ff @(posedge i_dotclk) begin
    if (i_reset || i_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_advance) begin
      if (r_col == LastCol) begin
        r_col <= '0;
        r_row <= r_row + 9'd1;
      end else begin
        r_col <= r_col + 10'd1;
      end
    end
  end

  // 16x16 checkerboard
  assign o_data = r_col[4] ^ r_row[4];
`else
  assign o_data = 1'b0;
`endif

endmodule

// File: rtl/fb_write_sched.sv
// fb_write_sched: shares the frame-RAM write port between pixel capture and a
// clear engine. Capture always wins; clearing uses idle cycles. All outputs
// are registered.
// Optional feature macro: FB_TESTPAT_EN (clear writes a checkerboard).
// Ports:
//   i_dotclk        - clock
//   i_reset         - synchronous active-high reset
//   i_cap_valid     - capture write request (cannot be stalled)
//   i_cap_addr      - capture address
//   i_cap_data      - capture pixel value
//   i_clr_start     - pulse: start/restart a full clear
//   o_waddr         - RAM write address
//   o_pixel_state   - RAM write data
//   o_wren          - RAM write enable
//   o_clr_busy      - clear engine has words outstanding
//   o_clr_done      - pulse after the final clear word was written
//   o_cap_drop      - pulse: out-of-range capture discarded
module fb_write_sched
  import fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT = fb_pkg::FB_HEIGHT,
  parameter int unsigned FB_WORDS  = FB_WIDTH * FB_HEIGHT
) (
  input  logic     i_dotclk,
  input  logic     i_reset,
  input  logic     i_cap_valid,
  input  fb_addr_t i_cap_addr,
  input  logic     i_cap_data,
  input  logic     i_clr_start,
  output fb_addr_t o_waddr,
  output logic     o_pixel_state,
  output logic     o_wren,
  output logic     o_clr_busy,
  output logic     o_clr_done,
  output logic     o_cap_drop
);

  localparam fb_addr_t LastAddr = fb_addr_t'(FB_WORDS - 1);

  if (FB_WORDS == 0 || FB_WORDS > 262144 || FB_WORDS > FB_WIDTH * FB_HEIGHT) begin : g_bad_words
    $error("fb_write_sched: FB_WORDS must be 1..min(2^18, FB_WIDTH*FB_HEIGHT)");
  end

  sched_state_t r_state, w_state_next;

  fb_addr_t w_clr_addr;
  logic     w_clr_data;
  logic     w_clr_last;
  logic     w_grant;
  logic     w_cap_in_range;

  // A dropped capture still occupies the slot, so the grant looks only at valid.
  assign w_grant        = (r_state == CLEAR) && !i_cap_valid;
  assign w_cap_in_range = (i_cap_addr <= LastAddr);

  fb_clear_gen #(
    .Width (FB_WIDTH),
    .Words (FB_WORDS)
  ) u_clear_gen (
    .i_dotclk  (i_dotclk),
    .i_reset   (i_reset),
    .i_start   (i_clr_start),
    .i_advance (w_grant),
    .o_addr    (w_clr_addr),
    .o_data    (w_clr_data),
    .o_last    (w_clr_last)
  );

  // State register
  always_ff @(posedge i_dotclk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    w_state_next = IDLE;
      CLEAR:   if (w_grant && w_clr_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (i_clr_start) begin
      w_state_next = CLEAR;
    end
  end

  // Output logic (registered below)
  fb_addr_t w_waddr;
  logic     w_data;
  logic     w_wren;
  logic     w_drop;
  logic     w_busy;
  logic     w_done;

  always_comb begin
    w_waddr = o_waddr;
    w_data  = o_pixel_state;
    w_wren  = 1'b0;
    w_drop  = 1'b0;
    if (i_cap_valid) begin
      if (w_cap_in_range) begin
        w_wren  = 1'b1;
        w_waddr = i_cap_addr;
        w_data  = i_cap_data;
      end else begin
        w_drop = 1'b1;
      end
    end else if (w_grant) begin
      w_wren  = 1'b1;
      w_waddr = w_clr_addr;
      w_data  = w_clr_data;
    end
    // Registered off the current state: busy lines up with the clear writes and
    // done lands the cycle after the final write.
    w_busy = (r_state == CLEAR);
    w_done = (r_state == DONE);
  end

  fb_addr_t r_waddr;
  logic     r_pixel_state;
  logic     r_wren;
  logic     r_clr_busy;
  logic     r_clr_done;
  logic     r_cap_drop;

  always_ff @(posedge i_dotclk) begin
    if (i_reset) begin
      r_waddr       <= '0;
      r_pixel_state <= 1'b0;
      r_wren        <= 1'b0;
      r_clr_busy    <= 1'b0;
      r_clr_done    <= 1'b0;
      r_cap_drop    <= 1'b0;
    end else begin
      r_waddr       <= w_waddr;
      r_pixel_state <= w_data;
      r_wren        <= w_wren;
      r_clr_busy    <= w_busy;
      r_clr_done    <= w_done;
      r_cap_drop    <= w_drop;
    end
  end

  assign o_waddr       = r_waddr;
  assign o_pixel_state = r_pixel_state;
  assign o_wren        = r_wren;
  assign o_clr_busy    = r_clr_busy;
  assign o_clr_done    = r_clr_done;
  assign o_cap_drop    = r_cap_drop;

endmodule

// File: tb/tb_fb_write_sched.sv
// Scoreboard bench for fb_write_sched. Stimulus pushes expected write/drop/done
// events (tagged with the cycle they must appear in); a negedge monitor pops and
// compares whenever the DUT shows wren, cap_drop or clr_done.
module tb_fb_write_sched;

`ifdef FB_TESTPAT_EN
  localparam int unsigned TbWidth  = 32;
  localparam int unsigned TbHeight = 1;
`else
  localparam int unsigned TbWidth  = 8;
  localparam int unsigned TbHeight = 2;
`endif
  localparam int unsigned TbWords = TbWidth * TbHeight;

  localparam int EvWrite = 0;
  localparam int EvDrop  = 1;
  localparam int EvDone  = 2;

  typedef struct {
    int          kind;
    int unsigned addr;
    logic        data;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cap_valid = 1'b0;
  logic [17:0] cap_addr = '0;
  logic        cap_data = 1'b0;
  logic        clr_start = 1'b0;
  logic [17:0] waddr;
  logic        pixel_state;
  logic        wren;
  logic        clr_busy;
  logic        clr_done;
  logic        cap_drop;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ev_t exp_q[$];

  // Bench-side view of the clear engine
  bit          m_clear = 1'b0;
  int unsigned m_ptr   = 0;

  fb_write_sched #(
    .FB_WIDTH  (TbWidth),
    .FB_HEIGHT (TbHeight),
    .FB_WORDS  (TbWords)
  ) dut (
    .i_dotclk      (clk),
    .i_reset       (rst),
    .i_cap_valid   (cap_valid),
    .i_cap_addr    (cap_addr),
    .i_cap_data    (cap_data),
    .i_clr_start   (clr_start),
    .o_waddr       (waddr),
    .o_pixel_state (pixel_state),
    .o_wren        (wren),
    .o_clr_busy    (clr_busy),
    .o_clr_done    (clr_done),
    .o_cap_drop    (cap_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic clear_data(input int unsigned ptr);
`ifdef FB_TESTPAT_EN
    int unsigned col;
    int unsigned row;
    col = ptr % TbWidth;
    row = ptr / TbWidth;
    return col[4] ^ row[4];
`else
    return (ptr > TbWords); // never true: plain clear data is 0
`endif
  endfunction

  function automatic void push(input int kind, input int unsigned addr, input logic data,
                               input int when);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.cyc  = when;
    exp_q.push_back(e);
  endfunction

  task automatic check_ev(input int kind, input int unsigned addr, input logic data);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got kind=%0d addr=%0d data=%0b cyc=%0d, expected none",
               kind, addr, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr != addr || e.data != data || e.cyc != cyc) begin
        bad++;
        $display("FAIL event got kind=%0d addr=%0d data=%0b cyc=%0d, want kind=%0d addr=%0d data=%0b cyc=%0d",
                 kind, addr, data, cyc, e.kind, e.addr, e.data, e.cyc);
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (clr_done) check_ev(EvDone, 0, 1'b0);
    if (cap_drop) check_ev(EvDrop, 0, 1'b0);
    if (wren)     check_ev(EvWrite, int'(waddr), pixel_state);
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // One clock of stimulus; expected events are queued before the edge.
  task automatic step(input bit v, input int unsigned a, input bit d, input bit s, input bit r);
    int  c;
    bit  busy_exp;
    c = cyc;
    cap_valid = v;
    cap_addr  = 18'(a);
    cap_data  = d;
    clr_start = s;
    rst       = r;
    busy_exp  = r ? 1'b0 : m_clear;
    if (r) begin
      m_clear = 1'b0;
      m_ptr   = 0;
    end else begin
      if (v) begin
        if (a < TbWords) push(EvWrite, a, d, c + 1);
        else             push(EvDrop, 0, 1'b0, c + 1);
      end else if (m_clear) begin
        push(EvWrite, m_ptr, clear_data(m_ptr), c + 1);
        if (m_ptr == TbWords - 1 && !s) begin
          m_clear = 1'b0;
          push(EvDone, 0, 1'b0, c + 2);
        end else begin
          m_ptr++;
        end
      end
      if (s) begin
        m_clear = 1'b1;
        m_ptr   = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("clr_busy", int'(clr_busy), int'(busy_exp));
    if (r) begin
      chk("reset_waddr", int'(waddr), 0);
      chk("reset_pixel", int'(pixel_state), 0);
      chk("reset_wren", int'(wren), 0);
      chk("reset_done", int'(clr_done), 0);
      chk("reset_drop", int'(cap_drop), 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held with capture requesting
    for (int i = 0; i < 3; i++) step(1'b1, 5, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Capture pass-through and range boundaries
    step(1'b1, 12, 1'b1, 1'b0, 1'b0);
    step(1'b1, TbWords - 1, 1'b0, 1'b0, 1'b0);
    step(1'b1, TbWords, 1'b1, 1'b0, 1'b0);
    step(1'b1, 256000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Uncontended clear
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(TbWords + 3);

    // Contention: three captures interleaved with the clear
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < int'(TbWords) + 6; k++) begin
      if (k == 2)      step(1'b1, 3, 1'b1, 1'b0, 1'b0);
      else if (k == 5) step(1'b1, 9, 1'b1, 1'b0, 1'b0);
      else if (k == 9) step(1'b1, 14, 1'b1, 1'b0, 1'b0);
      else             idle(1);
    end

    // clr_start together with a capture from IDLE
    step(1'b1, 4, 1'b1, 1'b1, 1'b0);
    idle(TbWords + 3);

    // Restart at pointer 7
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(7);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(TbWords + 3);

    // Restart during DONE: done still pulses, then a full clear follows
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(TbWords);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(TbWords + 3);

    // Reset at pointer 5: no further writes and no done
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(TbWords + 3);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
